// File: rtl/msu_pkg.sv
// Shared constants for the multi-channel MSU register block: register offsets,
// MCU status mask bit positions, ID string bytes and default revision.
package msu_pkg;

    typedef enum logic [3:0] {
        REG_ADDR0    = 4'd0,
        REG_ADDR1    = 4'd1,
        REG_ADDR2    = 4'd2,
        REG_ADDR3    = 4'd3,
        REG_TRACK_LO = 4'd4,
        REG_TRACK_HI = 4'd5,
        REG_VOLUME   = 4'd6,
        REG_CTRL     = 4'd7,
        REG_CHSEL    = 4'd8
    } msu_reg_e;

    // Read side reuses the write offsets for the status and data ports.
    localparam msu_reg_e REG_STATUS = REG_ADDR0;
    localparam msu_reg_e REG_DATA   = REG_ADDR1;

    localparam int ST_AUDIO_BUSY  = 5;
    localparam int ST_DATA_BUSY   = 4;
    localparam int ST_AUDIO_ERROR = 3;
    localparam int ST_AUDIO_STAT  = 1;
    localparam int ST_CTRL_START  = 0;

    localparam int MSU_REV = 2;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] id_byte(input logic [3:0] off);
        case (off)
            4'd2:    return 8'h53;
            4'd3:    return 8'h2D;
            4'd4:    return 8'h4D;
            4'd5:    return 8'h53;
            4'd6:    return 8'h55;
            4'd7:    return 8'h31;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/msu_databuf_sdp.sv
// Simple dual-port byte RAM for the MSU data stream: MCU writes one port,
// SNES read pointer reads the other with one clock of latency.
module msu_databuf_sdp #(
    parameter int AW = 14
) (
    input  logic          clkin,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clkin) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/msu_multi.sv
// MSU-1 compatible register/data-port block with NUM_CH audio channels,
// a half-buffer refill request and lossless MCU status updates.
module msu_multi
    import msu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int BUF_AW = 14,
    parameter int REV    = MSU_REV
) (
    input  logic                        clkin,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [3:0]                  reg_addr,
    input  logic [7:0]                  reg_data_in,
    output logic [7:0]                  reg_data_out,
    input  logic                        reg_oe_falling,
    input  logic                        reg_oe_rising,
    input  logic                        reg_we_rising,
    input  logic [BUF_AW-1:0]           pgm_address,
    input  logic [7:0]                  pgm_data,
    input  logic                        pgm_we,
    input  logic [BUF_AW-1:0]           msu_address_ext,
    input  logic                        msu_address_ext_write,
    input  logic [ch_width(NUM_CH)-1:0] mcu_ch,
    input  logic [5:0]                  status_set_bits,
    input  logic [5:0]                  status_reset_bits,
    input  logic                        status_reset_we,
    input  logic                        refill_ack,
    output logic [7:0]                  status_out,
    output logic [NUM_CH-1:0]           pend_out,
    output logic [31:0]                 addr_out,
    output logic [15:0]                 track_out,
    output logic [7:0]                  volume_out,
    output logic                        volume_latch_out,
    output logic [ch_width(NUM_CH)-1:0] volume_ch_out,
    output logic                        refill_req
);

    localparam int         CH_W     = ch_width(NUM_CH);
    localparam logic [2:0] REV_BITS = 3'(REV);

    logic [2:0]        seek_sync, stat_sync;
    logic              seek_pulse, stat_pulse;
    logic              bus_we, bus_oe_fall, bus_oe_rise;
    logic              wr_track_lo, wr_track_hi, wr_volume, wr_ctrl, wr_chsel, wr_addr3;
    logic              ptr_inc_en, mcu_ch_ok;
    logic [BUF_AW-1:0] ptr, ptr_next_inc;
    logic [7:0]        buf_rdata, rd_mux;

    logic [CH_W-1:0]   chsel;
    logic              data_busy, data_start;
    logic [NUM_CH-1:0] audio_busy, audio_start, audio_error, ctrl_start, vol_start;
    logic [NUM_CH-1:0] mcu_hit, snes_hit;
    logic [1:0]        audio_status [NUM_CH];
    logic [2:0]        ctrl         [NUM_CH];
    logic [15:0]       track        [NUM_CH];
    logic [7:0]        volume       [NUM_CH];

    // Both MCU levels are asynchronous; the third stage gives a rising-edge pulse.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            seek_sync <= '0;
            stat_sync <= '0;
        end else begin
            seek_sync <= {seek_sync[1:0], msu_address_ext_write};
            stat_sync <= {stat_sync[1:0], status_reset_we};
        end
    end

    assign seek_pulse  = seek_sync[1] & ~seek_sync[2];
    assign stat_pulse  = stat_sync[1] & ~stat_sync[2];
    assign bus_we      = reg_we_rising & enable;
    assign bus_oe_fall = reg_oe_falling & enable;
    assign bus_oe_rise = reg_oe_rising & enable;
    assign wr_addr3    = bus_we && (reg_addr == REG_ADDR3);
    assign wr_track_lo = bus_we && (reg_addr == REG_TRACK_LO);
    assign wr_track_hi = bus_we && (reg_addr == REG_TRACK_HI);
    assign wr_volume   = bus_we && (reg_addr == REG_VOLUME);
    assign wr_ctrl     = bus_we && (reg_addr == REG_CTRL);
    assign wr_chsel    = bus_we && (reg_addr == REG_CHSEL) && (32'(reg_data_in) < 32'(NUM_CH));
    assign mcu_ch_ok   = 32'(mcu_ch) < 32'(NUM_CH);
    assign ptr_inc_en  = bus_oe_rise && (reg_addr == REG_DATA) && !seek_pulse;
    assign ptr_next_inc = ptr + 1'b1;

    // Only increments can raise refill_req; a seek never does.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            refill_req <= 1'b0;
        end else begin
            if (seek_pulse) begin
                ptr <= msu_address_ext;
            end else if (ptr_inc_en) begin
                ptr <= ptr_next_inc;
            end
            if (ptr_inc_en && (ptr_next_inc[BUF_AW-1] != ptr[BUF_AW-1])) begin
                refill_req <= 1'b1;
            end else if (refill_ack) begin
                refill_req <= 1'b0;
            end
        end
    end

    msu_databuf_sdp #(.AW(BUF_AW)) u_databuf (
        .clkin (clkin),
        .we    (~pgm_we),
        .waddr (pgm_address),
        .wdata (pgm_data),
        .raddr (ptr),
        .rdata (buf_rdata)
    );

    always_comb begin
        mcu_hit  = '0;
        snes_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mcu_hit[i]  = stat_pulse && (mcu_ch == CH_W'(i));
            snes_hit[i] = (chsel == CH_W'(i));
        end
    end

    // MCU mask applied first so a same-cycle SNES set overrides an MCU clear.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            audio_busy  <= '1;
            audio_start <= '0;
            audio_error <= '0;
            ctrl_start  <= '0;
            vol_start   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                audio_status[i] <= '0;
                ctrl[i]         <= '0;
                track[i]        <= '0;
                volume[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mcu_hit[i]) begin
                    audio_busy[i]   <= (audio_busy[i] | status_set_bits[ST_AUDIO_BUSY])
                                       & ~status_reset_bits[ST_AUDIO_BUSY];
                    audio_error[i]  <= (audio_error[i] | status_set_bits[ST_AUDIO_ERROR])
                                       & ~status_reset_bits[ST_AUDIO_ERROR];
                    audio_status[i] <= (audio_status[i] | status_set_bits[ST_AUDIO_STAT +: 2])
                                       & ~status_reset_bits[ST_AUDIO_STAT +: 2];
                    ctrl_start[i]   <= (ctrl_start[i] | status_set_bits[ST_CTRL_START])
                                       & ~status_reset_bits[ST_CTRL_START];
                    if (status_reset_bits[ST_AUDIO_BUSY]) begin
                        audio_start[i] <= 1'b0;
                    end
                end
                if (snes_hit[i]) begin
                    if (wr_track_lo) begin
                        track[i][7:0] <= reg_data_in;
                    end
                    if (wr_track_hi) begin
                        track[i][15:8] <= reg_data_in;
                        audio_busy[i]  <= 1'b1;
                        audio_start[i] <= 1'b1;
                    end
                    if (wr_volume) begin
                        volume[i]    <= reg_data_in;
                        vol_start[i] <= 1'b1;
                    end
                    if (wr_ctrl && !audio_busy[i]) begin
                        ctrl[i]       <= reg_data_in[2:0];
                        ctrl_start[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            addr_out         <= '0;
            data_busy        <= 1'b1;
            data_start       <= 1'b0;
            chsel            <= '0;
            volume_latch_out <= 1'b0;
            volume_ch_out    <= '0;
        end else begin
            if (bus_we && (reg_addr[3:2] == 2'b00)) begin
                addr_out[{reg_addr[1:0], 3'b000} +: 8] <= reg_data_in;
            end
            if (stat_pulse) begin
                data_busy <= (data_busy | status_set_bits[ST_DATA_BUSY])
                             & ~status_reset_bits[ST_DATA_BUSY];
                if (status_reset_bits[ST_DATA_BUSY]) begin
                    data_start <= 1'b0;
                end
            end
            if (wr_addr3) begin
                data_busy  <= 1'b1;
                data_start <= 1'b1;
            end
            if (wr_chsel) begin
                chsel <= reg_data_in[CH_W-1:0];
            end
            volume_latch_out <= wr_volume;
            if (wr_volume) begin
                volume_ch_out <= chsel;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_STATUS: rd_mux = {data_busy, audio_busy[chsel], audio_status[chsel],
                                  audio_error[chsel], REV_BITS};
            REG_DATA:   rd_mux = buf_rdata;
            REG_CHSEL:  rd_mux[CH_W-1:0] = chsel;
            default:    rd_mux = id_byte(reg_addr);
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            reg_data_out <= '0;
        end else if (bus_oe_fall) begin
            reg_data_out <= rd_mux;
        end
    end

    always_comb begin
        status_out    = '0;
        track_out     = '0;
        volume_out    = '0;
        status_out[7] = ptr[BUF_AW-1];
        status_out[5] = data_start;
        if (mcu_ch_ok) begin
            status_out[6]   = audio_start[mcu_ch];
            status_out[4]   = vol_start[mcu_ch];
            status_out[3:1] = ctrl[mcu_ch];
            status_out[0]   = ctrl_start[mcu_ch];
            track_out       = track[mcu_ch];
            volume_out      = volume[mcu_ch];
        end
    end

    assign pend_out = audio_start | vol_start | ctrl_start;

endmodule
